// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared types and constants for the mic frequency scheduler
package mic_pkg;

    localparam int CH_IDX_W          = 2;
    localparam int DEF_GATE_CYCLES   = 100_000_000;
    localparam int DEF_SETTLE_CYCLES = 1_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_GATE,
        ST_REPORT
    } state_e;

endpackage

// File: rtl/mic_edge_sync.sv
// rtl/mic_edge_sync.sv - 2-FF synchronizer plus one-cycle falling-edge pulse for one mic pin
module mic_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops clear to 0 so a pin that is already high at reset release reads as a rise, never a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/mic_freq_scheduler.sv
// rtl/mic_freq_scheduler.sv - round-robin gated falling-edge counter shared by NUM_CH mic inputs
// Optional in-band flag built only when MIC_FREQ_BAND_EN is defined.
module mic_freq_scheduler
    import mic_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int HZ_W          = 10,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
`ifdef MIC_FREQ_BAND_EN
    ,
    parameter int BAND_LO       = 400,
    parameter int BAND_HI       = 600
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   mic_in,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic [HZ_W-1:0]     hz_out,
    output logic [CH_IDX_W-1:0] hz_ch,
    output logic                hz_ovf,
    output logic                hz_valid,
    input  logic                hz_ready,
    output logic                in_band,
    output logic                busy
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [HZ_W-1:0]  CNT_MAX     = '1;

    logic [NUM_CH-1:0] fall;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        mic_edge_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .pin_i  (mic_in[g]),
            .fall_o (fall[g])
        );
    end

    state_e              state_q,   state_d;
    logic [CH_IDX_W-1:0] rr_q,      rr_d;
    logic [CH_IDX_W-1:0] cur_ch_q,  cur_ch_d;
    logic [TMR_W-1:0]    timer_q,   timer_d;
    logic [HZ_W-1:0]     count_q,   count_d;
    logic                ovf_q,     ovf_d;
    logic [HZ_W-1:0]     hz_out_q,  hz_out_d;
    logic [CH_IDX_W-1:0] hz_ch_q,   hz_ch_d;
    logic                hz_ovf_q,  hz_ovf_d;

    logic [CH_IDX_W-1:0] sel_hi, sel_lo, sel_ch, rr_next;
    logic                hit_hi, hit_lo;
    logic                cur_pulse;
    logic [HZ_W-1:0]     cnt_fin;
    logic                ovf_fin;

    // Lowest masked-in channel at or above rr, else the lowest one overall (wrap).
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_mask[c]) begin
                sel_lo = CH_IDX_W'(c);
                hit_lo = 1'b1;
                if (CH_IDX_W'(c) >= rr_q) begin
                    sel_hi = CH_IDX_W'(c);
                    hit_hi = 1'b1;
                end
            end
        end
        sel_ch  = hit_hi ? sel_hi : sel_lo;
        rr_next = (cur_ch_q == CH_IDX_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;
    end

    always_comb begin
        cur_pulse = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_ch_q == CH_IDX_W'(c)) begin
                cur_pulse = fall[c];
            end
        end
        cnt_fin = count_q;
        ovf_fin = ovf_q;
        if (cur_pulse) begin
            if (count_q == CNT_MAX) begin
                ovf_fin = 1'b1;
            end else begin
                cnt_fin = count_q + 1'b1;
            end
        end
    end

`ifdef MIC_FREQ_BAND_EN
    logic in_band_q, in_band_d;
    logic band_hit;

    always_comb begin
        band_hit = !ovf_fin && (int'(cnt_fin) >= BAND_LO) && (int'(cnt_fin) <= BAND_HI);
    end
`endif

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cur_ch_d = cur_ch_q;
        timer_d  = timer_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        hz_out_d = hz_out_q;
        hz_ch_d  = hz_ch_q;
        hz_ovf_d = hz_ovf_q;
`ifdef MIC_FREQ_BAND_EN
        in_band_d = in_band_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && (|ch_mask)) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!enable || !hit_lo) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_ch_d = sel_ch;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    timer_d  = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    timer_d = GATE_LOAD;
                    state_d = ST_GATE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = cnt_fin;
                    ovf_d   = ovf_fin;
                    if (timer_q == '0) begin
                        hz_out_d = cnt_fin;
                        hz_ch_d  = cur_ch_q;
                        hz_ovf_d = ovf_fin;
`ifdef MIC_FREQ_BAND_EN
                        in_band_d = band_hit;
`endif
                        state_d  = ST_REPORT;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                if (hz_ready) begin
                    rr_d    = rr_next;
                    state_d = enable ? ST_SELECT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            cur_ch_q <= '0;
            timer_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            hz_out_q <= '0;
            hz_ch_q  <= '0;
            hz_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cur_ch_q <= cur_ch_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            hz_out_q <= hz_out_d;
            hz_ch_q  <= hz_ch_d;
            hz_ovf_q <= hz_ovf_d;
        end
    end

`ifdef MIC_FREQ_BAND_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            in_band_q <= 1'b0;
        end else begin
            in_band_q <= in_band_d;
        end
    end

    assign in_band = in_band_q;
`else
    assign in_band = 1'b0;
`endif

    assign hz_out   = hz_out_q;
    assign hz_ch    = hz_ch_q;
    assign hz_ovf   = hz_ovf_q;
    assign hz_valid = (state_q == ST_REPORT);
    assign busy     = (state_q != ST_IDLE);

endmodule
